// File: rtl/calc_io_sequencer.sv
// calc_io_sequencer
//   Drives an operation/operand pair into a small CPU through its input ports
//   (pe0 = op, pe1 = arg), waits for the CPU program to raise its ready bit on
//   ps0, captures the result from ps1, then waits for the ready bit to drop
//   before accepting the next pair.
//
//   Sequence: IDLE -> LOAD_OP (op, 00) -> LOAD_ARG (op, arg) -> WAIT_ACK
//             -> RELEASE (00, 00) -> IDLE
//
// Parameters
//   HOLD_CYCLES    cycles each value is held on pe0/pe1 (1..255)
//   ACK_BIT        bit of ps0 that signals "result ready"
//   TIMEOUT_CYCLES acknowledge-wait limit (1..1023), timeout build only
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   host handshake; in_ready only in IDLE
//   in_op, in_arg       pair latched on the accept edge
//   pe0, pe1            registered drives of CPU input ports 0/1
//   ps0, ps1            CPU status / result output ports
//   res_valid, res_data one-cycle result pulse and captured result
//   busy                high in every state except IDLE
//   err                 one-cycle acknowledge-timeout pulse
//
// Build option
//   CALC_IO_SEQUENCER_TIMEOUT_EN: when defined, WAIT_ACK or RELEASE lasting
//   TIMEOUT_CYCLES cycles pulses err and returns to IDLE. When undefined the
//   sequencer waits forever and err is tied low.
module calc_io_sequencer #(
  parameter int HOLD_CYCLES    = 16,
  parameter int ACK_BIT        = 0,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_op,
  input  logic [7:0] in_arg,
  output logic [7:0] pe0,
  output logic [7:0] pe1,
  input  logic [7:0] ps0,
  input  logic [7:0] ps1,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       busy,
  output logic       err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_OP  = 3'd1;
  localparam logic [2:0] S_LOAD_ARG = 3'd2;
  localparam logic [2:0] S_WAIT_ACK = 3'd3;
  localparam logic [2:0] S_RELEASE  = 3'd4;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  // Catch out-of-range parameters at elaboration.
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("HOLD_CYCLES out of range 1..255");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..1023");
  end
  if (ACK_BIT < 0 || ACK_BIT > 7) begin : g_bad_ack
    $error("ACK_BIT out of range 0..7");
  end

  logic [2:0] state;
  logic [7:0] op_q;
  logic [7:0] arg_q;
  logic [7:0] hold_cnt;
  logic       ack;
  logic       to_hit;

  assign ack      = ps0[ACK_BIT];
  assign in_ready = (state == S_IDLE) && !reset;
  assign busy     = (state != S_IDLE);

  // Only the acknowledge bit of ps0 carries meaning here.
  logic unused_ps0;
  assign unused_ps0 = ^ps0;

`ifdef CALC_IO_SEQUENCER_TIMEOUT_EN
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

  logic [9:0] wait_cnt;
  logic       waiting;

  assign waiting = (state == S_WAIT_ACK) || (state == S_RELEASE);
  // A pending state change (ack in WAIT_ACK, ack drop in RELEASE) wins over
  // the timeout in the same cycle.
  assign to_hit  = waiting && (wait_cnt == TO_LAST) &&
                   !((state == S_WAIT_ACK) && ack) &&
                   !((state == S_RELEASE) && !ack);

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= to_hit;
      // Restart on entry to WAIT_ACK (held at 0 outside the wait states) and
      // on the WAIT_ACK -> RELEASE move.
      if (!waiting || ((state == S_WAIT_ACK) && ack) || to_hit)
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + 10'd1;
    end
  end
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= '0;
      arg_q     <= '0;
      hold_cnt  <= '0;
      pe0       <= '0;
      pe1       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q     <= in_op;
            arg_q    <= in_arg;
            pe0      <= in_op;
            pe1      <= 8'h00;
            hold_cnt <= '0;
            state    <= S_LOAD_OP;
          end
        end
        S_LOAD_OP: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            pe1      <= arg_q;
            state    <= S_LOAD_ARG;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        S_LOAD_ARG: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            state    <= S_WAIT_ACK;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        S_WAIT_ACK: begin
          // Ack is sampled every WAIT_ACK cycle, including the first, so an
          // ack already high on entry completes immediately.
          if (ack) begin
            res_data  <= ps1;
            res_valid <= 1'b1;
            pe0       <= 8'h00;
            pe1       <= 8'h00;
            state     <= S_RELEASE;
          end else if (to_hit) begin
            pe0   <= 8'h00;
            pe1   <= 8'h00;
            state <= S_IDLE;
          end
        end
        S_RELEASE: begin
          if (!ack || to_hit) state <= S_IDLE;
        end
        default: begin
          pe0   <= 8'h00;
          pe1   <= 8'h00;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_io_sequencer.sv
// Self-checking bench for calc_io_sequencer (HOLD_CYCLES=4, TIMEOUT_CYCLES=8).
// Each transaction is described by its pair, the cycle window during which
// the CPU holds its ack bit, and the result value; expected port values per
// cycle follow from the phase boundaries counted from the accept edge.
module tb_calc_io_sequencer;
  localparam int H  = 4;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_op = '0, in_arg = '0, ps0 = '0, ps1 = '0;
  logic       in_ready, res_valid, busy, err;
  logic [7:0] pe0, pe1, res_data;

  calc_io_sequencer #(.HOLD_CYCLES(H), .ACK_BIT(0), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_arg(in_arg), .pe0(pe0), .pe1(pe1), .ps0(ps0),
    .ps1(ps1), .res_valid(res_valid), .res_data(res_data), .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] last_res = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // CPU status/result for one cycle: ack bit plus random noise elsewhere.
  task automatic drive_cpu(input logic ack, input logic [7:0] res, input logic use_res);
    logic [7:0] r;
    r   = 8'($urandom);
    ps0 = {r[7:1], ack};
    ps1 = use_res ? res : 8'($urandom);
  endtask

  // Starts at a negedge with the DUT in IDLE. Ack is high for cycles
  // [s, e) counted from the accept edge (cycle 0 = first LOAD_OP cycle).
  // Capture happens in cycle cap = max(s, 2H); the DUT is idle again in
  // cycle e+1. nv/nop/narg is what the host presents while busy.
  task automatic run_txn(input logic [7:0] op, input logic [7:0] arg,
                         input int s, input int e, input logic [7:0] res,
                         input logic nv, input logic [7:0] nop, input logic [7:0] narg);
    int cap;
    logic [7:0] xp0, xp1;
    cap = (s > 2*H) ? s : 2*H;
    chk("idle_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    in_valid = 1'b1; in_op = op; in_arg = arg;
    drive_cpu(1'b0, 8'h00, 1'b0);
    for (int k = 0; k <= e + 1; k++) begin
      @(negedge clk);
      xp0 = (k <= cap) ? op : 8'h00;
      xp1 = (k < H || k > cap) ? 8'h00 : arg;
      if (k == cap + 1) last_res = res;
      chk("pe0", pe0, xp0);
      chk("pe1", pe1, xp1);
      chk("busy", busy, (k <= e) ? 1 : 0);
      chk("in_ready", in_ready, (k > e) ? 1 : 0);
      chk("res_valid", res_valid, (k == cap + 1) ? 1 : 0);
      chk("res_data", res_data, last_res);
      chk("err", err, 0);
      in_valid = nv;
      in_op    = nv ? nop  : 8'($urandom);
      in_arg   = nv ? narg : 8'($urandom);
      if (k == e + 1) drive_cpu(1'b0, 8'h00, 1'b0);
      else            drive_cpu((k >= s && k < e), res, (k == cap));
    end
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_pe0", pe0, 0);
      chk("idle_pe1", pe1, 0);
      chk("idle_rv", res_valid, 0);
    end
  endtask

  logic [7:0] ops[13], args[13];
  logic       nvs[13];

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pe0", pe0, 0);
    chk("rst_pe1", pe1, 0);
    chk("rst_rv", res_valid, 0);
    chk("rst_rd", res_data, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic transaction: ack 3 cycles into WAIT_ACK
    run_txn(8'h06, 8'h05, 2*H + 3, 2*H + 5, 8'h0B, 1'b0, 8'h00, 8'h00);
    idle_cycles(2);

    // Ack already high during LOAD_ARG: capture in first WAIT_ACK cycle
    run_txn(8'h21, 8'h37, 2*H - 2, 2*H + 3, 8'h5A, 1'b0, 8'h00, 8'h00);
    idle_cycles(1);

    // Held request / back-to-back: second pair waits on in_valid throughout
    run_txn(8'h08, 8'h03, 2*H + 1, 2*H + 3, 8'h0B, 1'b1, 8'h08, 8'h05);
    run_txn(8'h08, 8'h05, 2*H,     2*H + 2, 8'h0D, 1'b0, 8'h00, 8'h00);
    idle_cycles(3);

    // Randomized transactions
    for (int i = 0; i < 13; i++) begin
      ops[i]  = 8'($urandom);
      args[i] = 8'($urandom);
      nvs[i]  = (i < 12) ? 1'($urandom) : 1'b0;
    end
    for (int i = 0; i < 12; i++) begin
      int s, cap, e;
      s   = int'($urandom_range(0, 2*H + 5));
      cap = (s > 2*H) ? s : 2*H;
      e   = cap + 1 + int'($urandom_range(0, 3));
      run_txn(ops[i], args[i], s, e, 8'($urandom), nvs[i], ops[i+1], args[i+1]);
    end
    idle_cycles(1);

`ifdef CALC_IO_SEQUENCER_TIMEOUT_EN
    // Ack never rises: err after TO WAIT_ACK cycles, then idle
    chk("to_ready", in_ready, 1);
    in_valid = 1'b1; in_op = 8'h44; in_arg = 8'h55;
    drive_cpu(1'b0, 8'h00, 1'b0);
    for (int k = 0; k <= 2*H + TO + 1; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (k < 2*H + TO) begin
        chk("to_busy", busy, 1);
        chk("to_err", err, 0);
      end else if (k == 2*H + TO) begin
        chk("to_err_pulse", err, 1);
        chk("to_busy_end", busy, 0);
        chk("to_pe0", pe0, 0);
        chk("to_pe1", pe1, 0);
        chk("to_rv", res_valid, 0);
      end else begin
        chk("to_err_clear", err, 0);
        chk("to_ready_end", in_ready, 1);
      end
      drive_cpu(1'b0, 8'h00, 1'b0);
    end
`else
    // Without the timeout the sequencer keeps waiting well past TO cycles
    run_txn(8'h44, 8'h55, 2*H + 30, 2*H + 32, 8'h99, 1'b0, 8'h00, 8'h00);
`endif
    idle_cycles(1);

    // Reset in the middle of LOAD_ARG
    chk("mid_ready", in_ready, 1);
    in_valid = 1'b1; in_op = 8'h77; in_arg = 8'h66;
    drive_cpu(1'b0, 8'h00, 1'b0);
    for (int k = 0; k <= H + 1; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      drive_cpu(1'b1, 8'hEE, 1'b1);
    end
    chk("mid_pe1_loaded", pe1, 8'h66);
    reset = 1'b1;
    @(negedge clk);
    last_res = 8'h00;
    chk("mr_pe0", pe0, 0);
    chk("mr_pe1", pe1, 0);
    chk("mr_rd", res_data, last_res);
    chk("mr_rv", res_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_err", err, 0);
    chk("mr_ready", in_ready, 0);
    reset = 1'b0;
    drive_cpu(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("mr_ready_after", in_ready, 1);
    idle_cycles(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/calc_io_sequencer.md
CALC_IO_SEQUENCER -- requirements
Module: calc_io_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16: cycles each value is held on the CPU input ports (legal range 1..255).
REQ-002 SHALL have parameter ACK_BIT, default 0: bit of ps0 that the CPU program raises when a result is ready.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1023: acknowledge-wait limit (legal range 1..1023); used only when TIMEOUT_EN is defined.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: host offers an operation/operand pair.
REQ-007 SHALL have port in_ready, output, 1: sequencer accepts the pair this cycle.
REQ-008 SHALL have port in_op, input, 8: operation code for CPU port Pe0.
REQ-009 SHALL have port in_arg, input, 8: operand for CPU port Pe1.
REQ-010 SHALL have port pe0, output, 8: drives CPU input port 0.
REQ-011 SHALL have port pe1, output, 8: drives CPU input port 1.
REQ-012 SHALL have port ps0, input, 8: CPU output port 0 (status).
REQ-013 SHALL have port ps1, input, 8: CPU output port 1 (result).
REQ-014 SHALL have port res_valid, output, 1: one-cycle pulse; res_data is valid.
REQ-015 SHALL have port res_data, output, 8: captured result.
REQ-016 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-017 SHALL have port err, output, 1: one-cycle timeout pulse.

Function
REQ-018 SHALL implement a registered FSM with states IDLE, LOAD_OP, LOAD_ARG, WAIT_ACK and RELEASE.
REQ-019 SHALL assert in_ready combinationally only in IDLE; in_valid outside IDLE is ignored and in_op/in_arg are not sampled.
REQ-020 SHALL latch in_op and in_arg on the edge where in_valid && in_ready, and move IDLE->LOAD_OP.
REQ-021 SHALL, in LOAD_OP, drive pe0=latched op and pe1=8'h00 for exactly HOLD_CYCLES cycles, then move to LOAD_ARG.
REQ-022 SHALL, in LOAD_ARG, drive pe0=latched op and pe1=latched arg for exactly HOLD_CYCLES cycles, then move to WAIT_ACK.
REQ-023 SHALL, in WAIT_ACK, hold pe0/pe1 as in LOAD_ARG; on the first cycle ps0[ACK_BIT]==1 it SHALL register res_data<=ps1, pulse res_valid for one cycle, and move to RELEASE.
REQ-024 SHALL, in RELEASE, drive pe0=8'h00 and pe1=8'h00 and return to IDLE on the first cycle ps0[ACK_BIT]==0.
REQ-025 SHALL drive pe0=pe1=8'h00 in IDLE; pe0/pe1 SHALL be registered outputs.
REQ-026 SHALL use one hold counter, cleared on every state entry; the counter SHALL never wrap within a state.
REQ-027 SHALL treat ps0[ACK_BIT] already high on WAIT_ACK entry as an immediate acknowledge in that cycle.
REQ-028 SHALL keep res_data unchanged between captures.
REQ-029 SHALL give a minimum latency of 2*HOLD_CYCLES+1 cycles from the accept edge to res_valid.

Reset
REQ-030 SHALL, while reset is high at a clock edge, force IDLE and pe0=pe1=res_data=8'h00 with res_valid=err=busy=0 and the counters cleared, regardless of state; in_ready SHALL be 0 while reset is high.
REQ-031 SHALL abandon any transaction in progress on reset without producing res_valid or err.

Configuration
REQ-032 SHALL compile a timeout when the macro CALC_IO_SEQUENCER_TIMEOUT_EN is defined: if WAIT_ACK or RELEASE lasts TIMEOUT_CYCLES cycles, the FSM SHALL pulse err for one cycle and go to IDLE with pe0=pe1=8'h00 and no res_valid.
REQ-033 SHALL, without CALC_IO_SEQUENCER_TIMEOUT_EN, wait indefinitely in WAIT_ACK/RELEASE, contain no timeout counter, and tie err to 0.

Verification
REQ-034 SHALL cover a basic transaction: HOLD_CYCLES=4, op=8'h06, arg=8'h05, ack after 3 cycles with ps1=8'h0B -> pe0=06/pe1=00 for 4 cycles, then 06/05 for 4 cycles; res_valid pulses once with res_data=0B; IDLE after ack drops.
REQ-035 SHALL cover a held request: in_valid held high with a new pair during busy -> exactly one accept per IDLE visit, no extra transaction.
REQ-036 SHALL cover a pre-asserted ack: ps0[0]=1 before WAIT_ACK -> res_valid in the first WAIT_ACK cycle (2*HOLD+1 after accept).
REQ-037 SHALL cover reset mid-LOAD_ARG: reset for 1 cycle -> all outputs at reset values next cycle, no res_valid, in_ready=1 after reset falls.
REQ-038 SHALL cover a timeout with the macro defined and TIMEOUT_CYCLES=8: ack never rises -> err pulses after 8 WAIT_ACK cycles, busy=0 next cycle; without the macro, busy stays 1.
REQ-039 SHALL cover back-to-back transactions: op=8'h08 arg=8'h03, then arg=8'h05 -> two res_valid pulses with the correct captured ps1 values each.
